// File: rtl/fetch_decode_buffer.sv
// rtl/fetch_decode_buffer.sv - fetch/decode buffer assembling 1- and 2-byte instructions
// Holds the instruction under decode, handles stall/flush and edge-triggered interrupt entry.
module fetch_decode_buffer #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       PC_W     = 8,
  parameter logic [DATA_W-1:0] NOP_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              intr,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] imm,
  output logic [3:0]        opcode,
  output logic [1:0]        ra,
  output logic [1:0]        rb,
  output logic [PC_W-1:0]   pc_next,
  output logic              ir_valid,
  output logic              imm_wait,
  output logic              decode_done,
  output logic [PC_W-1:0]   pc_saved
);

  localparam logic [1:0] ST_WARM  = 2'd0;
  localparam logic [1:0] ST_BYTE1 = 2'd1;
  localparam logic [1:0] ST_BYTE2 = 2'd2;

  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_LONG = 4'hC;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [PC_W-1:0] PC_TWO = PC_W'(2);

  logic [1:0]        state_q,       state_d;
  logic [DATA_W-1:0] ir_q,          ir_d;
  logic [DATA_W-1:0] imm_q,         imm_d;
  logic [PC_W-1:0]   pc1_q,         pc1_d;
  logic [PC_W-1:0]   pc_next_q,     pc_next_d;
  logic [PC_W-1:0]   pc_saved_q,    pc_saved_d;
  logic              ir_valid_q,    ir_valid_d;
  logic              decode_done_q, decode_done_d;
  logic              intr_prev_q,   intr_prev_d;
  logic              intr_pend_q,   intr_pend_d;

  logic intr_edge;
  logic take_intr;
  logic is_long;
  logic is_jump;

  assign intr_edge = intr & ~intr_prev_q;
  assign is_long   = (mem_data[7:4] == OP_LONG);
  assign is_jump   = (mem_data[7:4] == OP_JMP) && !mem_data[3];

  // An interrupt seen mid two-byte fetch waits until that instruction has been presented.
  assign take_intr = (intr_edge && (state_q != ST_BYTE2)) ||
                     (intr_pend_q && (state_q == ST_BYTE1));

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    imm_d         = imm_q;
    pc1_d         = pc1_q;
    pc_next_d     = pc_next_q;
    pc_saved_d    = pc_saved_q;
    ir_valid_d    = ir_valid_q;
    decode_done_d = 1'b0;
    intr_prev_d   = intr;
    intr_pend_d   = intr_pend_q;

    if (flush) begin
      ir_d        = NOP_BYTE;
      imm_d       = '0;
      ir_valid_d  = 1'b0;
      state_d     = ST_WARM;
      intr_pend_d = 1'b0;
    end else if (take_intr) begin
      ir_d        = NOP_BYTE;
      imm_d       = '0;
      ir_valid_d  = 1'b0;
      state_d     = ST_WARM;
      intr_pend_d = 1'b0;
      pc_saved_d  = intr_pend_q ? (pc1_q + PC_TWO) : pc_in;
    end else if (stall) begin
      if (intr_edge) begin
        intr_pend_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_WARM: begin
          ir_valid_d = 1'b0;
          state_d    = ST_BYTE1;
        end
        ST_BYTE1: begin
          ir_d  = mem_data;
          pc1_d = pc_in;
          imm_d = '0;
          if (is_long) begin
            ir_valid_d = 1'b0;
            state_d    = ST_BYTE2;
          end else begin
            ir_valid_d    = 1'b1;
            pc_next_d     = pc_in + PC_ONE;
            decode_done_d = is_jump;
          end
        end
        ST_BYTE2: begin
          imm_d      = mem_data;
          ir_valid_d = 1'b1;
          pc_next_d  = pc1_q + PC_TWO;
          state_d    = ST_BYTE1;
          if (intr_edge) begin
            intr_pend_d = 1'b1;
          end
        end
        default: begin
          ir_valid_d = 1'b0;
          state_d    = ST_WARM;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_WARM;
      ir_q          <= NOP_BYTE;
      imm_q         <= '0;
      pc1_q         <= '0;
      pc_next_q     <= '0;
      pc_saved_q    <= '0;
      ir_valid_q    <= 1'b0;
      decode_done_q <= 1'b0;
      intr_prev_q   <= 1'b0;
      intr_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      imm_q         <= imm_d;
      pc1_q         <= pc1_d;
      pc_next_q     <= pc_next_d;
      pc_saved_q    <= pc_saved_d;
      ir_valid_q    <= ir_valid_d;
      decode_done_q <= decode_done_d;
      intr_prev_q   <= intr_prev_d;
      intr_pend_q   <= intr_pend_d;
    end
  end

  assign ir          = ir_q;
  assign imm         = imm_q;
  assign opcode      = ir_q[7:4];
  assign ra          = ir_q[3:2];
  assign rb          = ir_q[1:0];
  assign pc_next     = pc_next_q;
  assign ir_valid    = ir_valid_q;
  assign imm_wait    = (state_q == ST_BYTE2);
  assign decode_done = decode_done_q;
  assign pc_saved    = pc_saved_q;

endmodule
